// File: rtl/mem_halfword_access.sv
// MEM-stage load/store sequencer: runs one req/ack memory transaction at a time,
// selects the addressed 16-bit lane for half-word loads and feeds the extender.
module mem_halfword_access #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_half,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_word,
    output logic [15:0] halfWord,
    output logic        SIG_ExtHalf,
    output logic        resp_is_half,
    output logic        misaligned,
    output logic        timeout,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       op_write;
    logic       op_half;
    logic       op_sign;
    logic       op_lane;
    logic       accept;
    logic       addr_bad;

    // Handshake: a request is consumed in any cycle where req_valid and req_ready
    // are both high; req_ready is high exactly when the sequencer is idle.
    assign req_ready = (state == S_IDLE);
    assign stall     = (state == S_IDLE) ? req_valid : 1'b1;
    assign accept    = req_valid && req_ready;
    assign addr_bad  = req_half ? req_addr[0] : (req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= 8'd0;
            op_write     <= 1'b0;
            op_half      <= 1'b0;
            op_sign      <= 1'b0;
            op_lane      <= 1'b0;
            resp_valid   <= 1'b0;
            resp_word    <= 32'd0;
            halfWord     <= 16'd0;
            SIG_ExtHalf  <= 1'b0;
            resp_is_half <= 1'b0;
            misaligned   <= 1'b0;
            timeout      <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_be       <= 4'd0;
        end else begin
            resp_valid <= 1'b0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                S_IDLE: begin
                    wait_cnt <= 8'd0;
                    if (accept) begin
                        if (addr_bad) begin
                            // Misaligned requests are consumed without touching memory.
                            misaligned <= 1'b1;
                        end else begin
                            state    <= S_WAIT;
                            op_write <= req_write;
                            op_half  <= req_half;
                            op_sign  <= req_sign;
                            op_lane  <= req_addr[1];
                            mem_req  <= 1'b1;
                            mem_we   <= req_write;
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_half) begin
                                mem_wdata <= {req_wdata[15:0], req_wdata[15:0]};
                                mem_be    <= req_addr[1] ? 4'b1100 : 4'b0011;
                            end else begin
                                mem_wdata <= req_wdata;
                                mem_be    <= 4'b1111;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        state      <= S_RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= 4'd0;
                        resp_valid <= 1'b1;
                        if (!op_write) begin
                            resp_word    <= mem_rdata;
                            halfWord     <= op_lane ? mem_rdata[31:16] : mem_rdata[15:0];
                            SIG_ExtHalf  <= op_sign;
                            resp_is_half <= op_half;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'd0;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
